// File: rtl/tiny_alu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : tiny_alu_core_if
// Description : start/done command bus between the tinyALU BFM (master) and
//               tiny_alu_core (slave). err exists only with TINY_ALU_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface tiny_alu_core_if;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] result;
    logic        done;
`ifdef TINY_ALU_ERR_EN
    logic        err;

    modport master (output start, op, a, b, input result, done, err);
    modport slave  (input start, op, a, b, output result, done, err);
`else
    modport master (output start, op, a, b, input result, done);
    modport slave  (input start, op, a, b, output result, done);
`endif
endinterface
`default_nettype wire

// File: rtl/tiny_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : tiny_alu_core
// Description : Responder side of the tinyALU start/done protocol. Single-cycle
//               add/and/xor/no_op/rst_op plus a MUL_LAT-cycle multiply.
//               Optional macro TINY_ALU_ERR_EN adds an err flag for 101/110.
// Revision    : 1.0 - initial release
// ============================================================================
module tiny_alu_core #(
    parameter int MUL_LAT = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    tiny_alu_core_if.slave    bus
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_mul_busy = 2'd1;
    localparam logic [1:0] c_st_done     = 2'd2;

    localparam logic [2:0] c_op_nop = 3'b000;
    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_xor = 3'b011;
    localparam logic [2:0] c_op_mul = 3'b100;
    localparam logic [2:0] c_op_rst = 3'b111;

    localparam logic [3:0] c_mul_load = 4'(MUL_LAT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_result;
    logic        r_done;
    logic [8:0]  w_sum;
    logic [15:0] w_prod;
    logic        w_illegal;
    logic [15:0] w_result;

    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_prod    = 16'(r_a) * 16'(r_b);
    assign w_illegal = (r_op == 3'b101) || (r_op == 3'b110);

    always_comb begin
        w_result = r_result;
        case (r_op)
            c_op_add: w_result = {7'b0, w_sum};
            c_op_and: w_result = {8'b0, r_a & r_b};
            c_op_xor: w_result = {8'b0, r_a ^ r_b};
            c_op_mul: w_result = w_prod;
            c_op_rst: w_result = 16'h0000;
            c_op_nop: w_result = r_result;
            default: begin
`ifdef TINY_ALU_ERR_EN
                w_result = 16'h0000;
`else
                w_result = r_result;
`endif
            end
        endcase
    end

`ifdef TINY_ALU_ERR_EN
    logic r_err;
    assign bus.err = r_err;
`endif

    // S_DONE is the cycle before the done pulse: result and done register on
    // its closing edge, so done falls on the edge where IDLE samples again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= 4'd0;
            r_op     <= 3'b000;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_result <= 16'h0000;
            r_done   <= 1'b0;
`ifdef TINY_ALU_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef TINY_ALU_ERR_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_op <= bus.op;
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                        if (bus.op == c_op_mul) begin
                            r_state <= c_st_mul_busy;
                            r_cnt   <= c_mul_load;
                        end else begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_mul_busy: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_result <= w_result;
                    r_done   <= 1'b1;
`ifdef TINY_ALU_ERR_EN
                    r_err    <= w_illegal;
`endif
                    r_state  <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifndef TINY_ALU_ERR_EN
    logic w_unused;
    assign w_unused = w_illegal;
`endif

    assign bus.result = r_result;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tiny_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_tiny_alu_core
// Description : Directed self-checking bench for tiny_alu_core (MUL_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny_alu_core;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    tiny_alu_core_if bus_if ();

    tiny_alu_core #(.MUL_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Drives a one-cycle start; returns at the negedge after the sample edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op = 3'b000;
        bus_if.a = 8'h00;
        bus_if.b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus_if.result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", bus_if.result);
        else n_pass++;
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus_if.done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        send(3'b001, 8'hFF, 8'h01);
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL add_done_early: got %b want 0", bus_if.done);
        else n_pass++;
        step();
        n_total++;
        if (bus_if.done !== 1'b1) $display("FAIL add_done: got %b want 1", bus_if.done);
        else n_pass++;
        n_total++;
        if (bus_if.result !== 16'h0100) $display("FAIL add_result: got %h want 0100", bus_if.result);
        else n_pass++;
        step();
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL add_done_fall: got %b want 0", bus_if.done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        send(3'b010, 8'hF0, 8'h3C);
        step();
        n_total++;
        if (bus_if.result !== 16'h0030 || bus_if.done !== 1'b1)
            $display("FAIL and_result: got %h/%b want 0030/1", bus_if.result, bus_if.done);
        else n_pass++;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = 3'b011;
        step();
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL b2b_done_fall: got %b want 0", bus_if.done);
        else n_pass++;
        @(negedge clk);
        bus_if.start = 1'b0;
        step();
        n_total++;
        if (bus_if.result !== 16'h00CC || bus_if.done !== 1'b1)
            $display("FAIL xor_result: got %h/%b want 00cc/1", bus_if.result, bus_if.done);
        else n_pass++;
        step();
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL xor_done_fall: got %b want 0", bus_if.done);
        else n_pass++;
    endtask

    task automatic test_mul();
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = 3'b100;
        bus_if.a     = 8'hFF;
        bus_if.b     = 8'hFF;
        @(negedge clk);
        bus_if.op = 3'b001;
        bus_if.a  = 8'h01;
        bus_if.b  = 8'h01;
        step();
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL mul_n1_done: got %b want 0", bus_if.done);
        else n_pass++;
        @(negedge clk);
        bus_if.start = 1'b0;
        step();
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL mul_n2_done: got %b want 0", bus_if.done);
        else n_pass++;
        step();
        n_total++;
        if (bus_if.done !== 1'b1 || bus_if.result !== 16'hFE01)
            $display("FAIL mul_result: got %h/%b want fe01/1", bus_if.result, bus_if.done);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (bus_if.done !== 1'b0 || bus_if.result !== 16'hFE01)
                $display("FAIL mul_after_%0d: got %h/%b want fe01/0", i, bus_if.result, bus_if.done);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = 3'b100;
        bus_if.a     = 8'h10;
        bus_if.b     = 8'h10;
        @(negedge clk);
        bus_if.start = 1'b0;
        rst = 1'b1;
        step();
        n_total++;
        if (bus_if.result !== 16'h0000) $display("FAIL midmul_rst_result: got %h want 0000", bus_if.result);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (bus_if.done !== 1'b0) $display("FAIL midmul_no_done_%0d: got %b want 0", i, bus_if.done);
            else n_pass++;
        end
        send(3'b001, 8'h02, 8'h03);
        step();
        n_total++;
        if (bus_if.result !== 16'h0005 || bus_if.done !== 1'b1)
            $display("FAIL midmul_add: got %h/%b want 0005/1", bus_if.result, bus_if.done);
        else n_pass++;
        step();
    endtask

    task automatic test_nop_rstop();
        send(3'b010, 8'hF0, 8'h3C);
        step();
        step();
        send(3'b000, 8'h11, 8'h22);
        step();
        n_total++;
        if (bus_if.result !== 16'h0030 || bus_if.done !== 1'b1)
            $display("FAIL nop: got %h/%b want 0030/1", bus_if.result, bus_if.done);
        else n_pass++;
        step();
        send(3'b111, 8'h11, 8'h22);
        step();
        n_total++;
        if (bus_if.result !== 16'h0000 || bus_if.done !== 1'b1)
            $display("FAIL rstop: got %h/%b want 0000/1", bus_if.result, bus_if.done);
        else n_pass++;
        step();
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL rstop_done_fall: got %b want 0", bus_if.done);
        else n_pass++;
    endtask

    task automatic test_illegal(input logic [2:0] op);
        send(3'b001, 8'h02, 8'h03);
        step();
`ifdef TINY_ALU_ERR_EN
        n_total++;
        if (bus_if.err !== 1'b0) $display("FAIL legal_err: got %b want 0", bus_if.err);
        else n_pass++;
`endif
        step();
        send(op, 8'hAA, 8'h55);
        step();
        n_total++;
        if (bus_if.done !== 1'b1) $display("FAIL illegal_done_%b: got %b want 1", op, bus_if.done);
        else n_pass++;
`ifdef TINY_ALU_ERR_EN
        n_total++;
        if (bus_if.err !== 1'b1 || bus_if.result !== 16'h0000)
            $display("FAIL illegal_err_%b: got %b/%h want 1/0000", op, bus_if.err, bus_if.result);
        else n_pass++;
`else
        n_total++;
        if (bus_if.result !== 16'h0005)
            $display("FAIL illegal_result_%b: got %h want 0005", op, bus_if.result);
        else n_pass++;
`endif
        step();
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL illegal_done_fall_%b: got %b want 0", op, bus_if.done);
        else n_pass++;
`ifdef TINY_ALU_ERR_EN
        n_total++;
        if (bus_if.err !== 1'b0) $display("FAIL illegal_err_fall_%b: got %b want 0", op, bus_if.err);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        test_nop_rstop();
        test_illegal(3'b101);
        test_illegal(3'b110);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
